// File: rtl/prim_ram_1p_rmw.sv
// rtl/prim_ram_1p_rmw.sv - read-modify-write front end for a full-word-only ECC single-port RAM
//
// Purpose:
//   Lets masked (partial) writes reach a downstream RAM wrapper that only accepts
//   full-word writes. A partial write drains outstanding reads, reads the old
//   word, merges the new bits under the mask and writes the whole word back.
//   Reads and full-word writes pass straight through. Internal RMW read data is
//   never forwarded upstream.
//
// Optional feature (macro RAM_RMW_UNCORR_DROP_EN):
//   defined     - an uncorrectable RMW read skips the write-back; RAM word unchanged.
//   not defined - the merged word is written anyway (re-encoded with clean ECC).
//   rmw_err_o pulses in both builds.
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_i/gnt_o/write_i/addr_i       upstream request handshake
//   wdata_i/wmask_i                  write data and bit-level mask
//   rvalid_o/rdata_o/rerror_o        upstream read response ({uncorr, corr})
//   rmw_err_o                        1-cycle pulse: RMW read was uncorrectable
//   ram_req_o/ram_write_o/ram_addr_o downstream request
//   ram_wdata_o/ram_wmask_o          downstream write data, mask always all ones
//   ram_rvalid_i/ram_rdata_i         downstream read response (corrected data)
//   ram_rerror_i                     downstream {uncorr, corr}

module prim_ram_1p_rmw #(
  parameter int Depth        = 512,
  parameter int Width        = 32,
  parameter int MaxRdLatency = 2,
  localparam int Aw          = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       rerror_o,
  output logic             rmw_err_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  input  logic [1:0]       ram_rerror_i
);

  localparam int OutsW = $clog2(MaxRdLatency + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2,
    WR    = 2'd3
  } state_e;

  state_e             state;
  logic [OutsW-1:0]   outs;
  logic [Aw-1:0]      addr_q;
  // Holds the upstream write data until the old word arrives, then the merged word.
  logic [Width-1:0]   wdata_q;
  logic [Width-1:0]   wmask_q;
  logic               rmw_err_q;

  logic               mask_full;
  logic               mask_none;
  logic               pass_rd;
  logic               pass_wr;
  logic               start_rmw;
  logic               rmw_rd;
  logic               fwd;
  logic               ram_req;
  logic [Width-1:0]   merged;

  assign mask_full = &wmask_i;
  assign mask_none = ~|wmask_i;

  assign pass_rd   = (state == IDLE) && req_i && !write_i;
  assign pass_wr   = (state == IDLE) && req_i && write_i && mask_full;
  assign start_rmw = (state == IDLE) && req_i && write_i && !mask_full && !mask_none;
  // The RMW read may only go out once every upstream read has been answered,
  // so its response can be told apart from forwarded ones.
  assign rmw_rd    = (state == DRAIN) && (outs == '0);
  assign fwd       = ram_rvalid_i && (state != WAIT);

  assign merged    = (ram_rdata_i & ~wmask_q) | (wdata_q & wmask_q);

  assign gnt_o     = (state == IDLE);

  always_comb begin
    ram_req     = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = addr_q;
    ram_wdata_o = wdata_q;
    case (state)
      IDLE: begin
        ram_req     = pass_rd || pass_wr;
        ram_write_o = write_i;
        ram_addr_o  = addr_i;
        ram_wdata_o = wdata_i;
      end
      DRAIN: begin
        ram_req = rmw_rd;
      end
      WR: begin
        ram_req     = 1'b1;
        ram_write_o = 1'b1;
      end
      default: begin
        ram_req = 1'b0;
      end
    endcase
  end

  // Request and response strobes are forced low while reset is held so nothing
  // escapes in either direction before the FSM is known to be idle.
  assign ram_req_o   = rst_ni && ram_req;
  assign ram_wmask_o = {Width{1'b1}};

  assign rvalid_o  = rst_ni && fwd;
  assign rdata_o   = ram_rdata_i;
  assign rerror_o  = rvalid_o ? ram_rerror_i : 2'b00;
  assign rmw_err_o = rmw_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      outs      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rmw_err_q <= 1'b0;
    end else begin
      // Forwarded responses only retire passthrough reads; guard against
      // underflow if a stray response ever shows up.
      case ({pass_rd, fwd && (outs != '0)})
        2'b10:   outs <= outs + OutsW'(1);
        2'b01:   outs <= outs - OutsW'(1);
        default: outs <= outs;
      endcase

      rmw_err_q <= (state == WAIT) && ram_rvalid_i && ram_rerror_i[1];

      case (state)
        IDLE: begin
          if (start_rmw) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wmask_q <= wmask_i;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (rmw_rd) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (ram_rvalid_i) begin
            // Corrected data is merged, so a correctable error is scrubbed.
            wdata_q <= merged;
`ifdef RAM_RMW_UNCORR_DROP_EN
            state   <= ram_rerror_i[1] ? IDLE : WR;
`else
            state   <= WR;
`endif
          end
        end
        WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prim_ram_1p_rmw.sv
// tb/tb_prim_ram_1p_rmw.sv - scoreboard bench for prim_ram_1p_rmw

module tb_prim_ram_1p_rmw;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, gnt_o, write_i;
  logic [8:0]  addr_i;
  logic [31:0] wdata_i, wmask_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rerror_o;
  logic        rmw_err_o;
  logic        ram_req_o, ram_write_o;
  logic [8:0]  ram_addr_o;
  logic [31:0] ram_wdata_o, ram_wmask_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;
  logic [1:0]  ram_rerror_i;

  always #5 clk = ~clk;

  prim_ram_1p_rmw dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .write_i      (write_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .wmask_i      (wmask_i),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .rerror_o     (rerror_o),
    .rmw_err_o    (rmw_err_o),
    .ram_req_o    (ram_req_o),
    .ram_write_o  (ram_write_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_wmask_o  (ram_wmask_o),
    .ram_rvalid_i (ram_rvalid_i),
    .ram_rdata_i  (ram_rdata_i),
    .ram_rerror_i (ram_rerror_i)
  );

  // Downstream RAM model, read latency 2, error injection on one address.
  logic [31:0] mem [512];
  logic        p1_v;
  logic [31:0] p1_d;
  logic [1:0]  p1_e;
  logic        err_en;
  logic [8:0]  err_addr;
  logic [1:0]  err_val;

  always @(posedge clk) begin
    if (!rst_ni) begin
      p1_v         <= 1'b0;
      ram_rvalid_i <= 1'b0;
    end else begin
      p1_v         <= ram_req_o && !ram_write_o;
      p1_d         <= mem[ram_addr_o];
      p1_e         <= (err_en && ram_addr_o == err_addr) ? err_val : 2'b00;
      ram_rvalid_i <= p1_v;
      ram_rdata_i  <= p1_d;
      ram_rerror_i <= p1_e;
      if (ram_req_o && ram_write_o) mem[ram_addr_o] <= ram_wdata_o;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: {rerror, rdata} expected per upstream read.
  logic [33:0] exp_q [$];
  int fwd_cnt = 0, wr_cnt = 0, rmw_rd_cnt = 0, rmw_fwd_snap = 0;
  int gnt_low_cnt = 0, rmw_err_cnt = 0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk) begin
    if (rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, rerror_o}, 32'hFFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("rdata", rdata_o, e[31:0]);
        chk("rerror", {30'd0, rerror_o}, {30'd0, e[33:32]});
      end
      fwd_cnt++;
    end
    if (ram_req_o && ram_write_o) begin
      wr_cnt++;
      last_wdata = ram_wdata_o;
      chk("ram_wmask", ram_wmask_o, 32'hFFFF_FFFF);
    end
    if (ram_req_o && !ram_write_o && !gnt_o) begin
      rmw_rd_cnt++;
      rmw_fwd_snap = fwd_cnt;
    end
    if (!gnt_o) gnt_low_cnt++;
    if (rmw_err_o) rmw_err_cnt++;
  end

  task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [31:0] m);
    int n;
    @(negedge clk);
    req_i = 1'b1; write_i = w; addr_i = a; wdata_i = d; wmask_i = m;
    n = 0;
    while (!gnt_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [31:0] d, input logic [1:0] e);
    exp_q.push_back({e, d});
    issue(1'b0, a, 32'd0, 32'hFFFF_FFFF);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_o && n < 50);
    if (!gnt_o) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_q_empty", exp_q.size(), 32'd0);
  endtask

  int wr0, rr0, g0, f0, e0;

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; write_i = 1'b0; addr_i = '0;
    wdata_i = '0; wmask_i = '0; err_en = 1'b0; err_addr = '0; err_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", {31'd0, gnt_o}, 32'd1);
    chk("reset_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("reset_ram_req", {31'd0, ram_req_o}, 32'd0);
    chk("reset_rmw_err", {31'd0, rmw_err_o}, 32'd0);
    rst_ni = 1'b1;

    // Full write then read back.
    issue(1'b1, 9'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    rd(9'd5, 32'hDEAD_BEEF, 2'b00);
    drain();

    // Partial write: one RMW read, one write of the merged word, gnt low 2+L.
    wr0 = wr_cnt; rr0 = rmw_rd_cnt; g0 = gnt_low_cnt;
    issue(1'b1, 9'd5, 32'h0000_1200, 32'h0000_FF00);
    wait_idle();
    chk("pw_rmw_reads", rmw_rd_cnt - rr0, 32'd1);
    chk("pw_writes", wr_cnt - wr0, 32'd1);
    chk("pw_wdata", last_wdata, 32'hDEAD_12EF);
    chk("pw_gnt_low", gnt_low_cnt - g0, 32'd4);
    rd(9'd5, 32'hDEAD_12EF, 2'b00);
    drain();

    // Two reads then a partial write back to back.
    issue(1'b1, 9'd1, 32'h1111_1111, 32'hFFFF_FFFF);
    issue(1'b1, 9'd2, 32'h2222_2222, 32'hFFFF_FFFF);
    drain();
    f0 = fwd_cnt; rr0 = rmw_rd_cnt;
    rd(9'd1, 32'h1111_1111, 2'b00);
    rd(9'd2, 32'h2222_2222, 2'b00);
    issue(1'b1, 9'd2, 32'h0000_00AB, 32'h0000_00FF);
    wait_idle();
    chk("drain_rmw_reads", rmw_rd_cnt - rr0, 32'd1);
    chk("drain_fwd_before_rmw", rmw_fwd_snap - f0, 32'd2);
    rd(9'd2, 32'h2222_22AB, 2'b00);
    drain();

    // Uncorrectable error on the RMW read.
    issue(1'b1, 9'd7, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    drain();
    err_en = 1'b1; err_addr = 9'd7; err_val = 2'b10;
    wr0 = wr_cnt; e0 = rmw_err_cnt;
    issue(1'b1, 9'd7, 32'h0000_005A, 32'h0000_00FF);
    wait_idle();
    repeat (2) @(negedge clk);
    err_en = 1'b0;
    chk("uncorr_rmw_err_pulse", rmw_err_cnt - e0, 32'd1);
`ifdef RAM_RMW_UNCORR_DROP_EN
    chk("uncorr_writes", wr_cnt - wr0, 32'd0);
    rd(9'd7, 32'hA5A5_A5A5, 2'b00);
`else
    chk("uncorr_writes", wr_cnt - wr0, 32'd1);
    chk("uncorr_wdata", last_wdata, 32'hA5A5_A55A);
    rd(9'd7, 32'hA5A5_A55A, 2'b00);
`endif
    drain();

    // Correctable error: forwarded on a plain read, scrubbed by RMW.
    issue(1'b1, 9'd8, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    drain();
    err_en = 1'b1; err_addr = 9'd8; err_val = 2'b01;
    rd(9'd8, 32'h0F0F_0F0F, 2'b01);
    drain();
    wr0 = wr_cnt; e0 = rmw_err_cnt;
    issue(1'b1, 9'd8, 32'hF000_0000, 32'hF000_0000);
    wait_idle();
    repeat (2) @(negedge clk);
    err_en = 1'b0;
    chk("corr_rmw_err_pulse", rmw_err_cnt - e0, 32'd0);
    chk("corr_writes", wr_cnt - wr0, 32'd1);
    chk("corr_wdata", last_wdata, 32'hFF0F_0F0F);
    rd(9'd8, 32'hFF0F_0F0F, 2'b00);
    drain();

    // Write with an empty mask is granted and dropped.
    wr0 = wr_cnt;
    @(negedge clk);
    req_i = 1'b1; write_i = 1'b1; addr_i = 9'd5; wdata_i = 32'hFFFF_FFFF; wmask_i = 32'd0;
    #1;
    chk("mask0_gnt", {31'd0, gnt_o}, 32'd1);
    chk("mask0_ram_req", {31'd0, ram_req_o}, 32'd0);
    @(posedge clk);
    #1 req_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("mask0_writes", wr_cnt - wr0, 32'd0);
    rd(9'd5, 32'hDEAD_12EF, 2'b00);
    drain();

    // Reset asserted while the RMW read is in flight.
    issue(1'b1, 9'd9, 32'h1234_5678, 32'hFFFF_FFFF);
    drain();
    wr0 = wr_cnt;
    issue(1'b1, 9'd9, 32'h0000_FFFF, 32'h0000_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b0;
    req_i = 1'b1; write_i = 1'b1; addr_i = 9'd9; wdata_i = 32'h0; wmask_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_gnt", {31'd0, gnt_o}, 32'd1);
      chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("rst_ram_req", {31'd0, ram_req_o}, 32'd0);
      @(negedge clk);
    end
    req_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_release_gnt", {31'd0, gnt_o}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_no_write", wr_cnt - wr0, 32'd0);
    rd(9'd9, 32'h1234_5678, 2'b00);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
